load_store_unit: RTL and testbench
==================================

# load_store_unit

Bus initiator between the MEM pipeline stage and the word-only data memory. Accepts one MIPS load/store request at a time and converts byte and halfword accesses into word accesses, using read-modify-write for sub-word stores. Returns sign- or zero-extended load data with a single-cycle response strobe. Flags misaligned accesses without touching memory.

## Interface
Parameters:
- `W`, `` `WORD_LEN `` (32): data and address width.

Ports:
- `clk` in 1: the single clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous and active-low, sampled on posedge `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request transfers when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_op` in 3: access size and sign. 000 = byte signed, 001 = half signed, 011 = word, 100 = byte unsigned, 101 = half unsigned. For stores, bit 2 is ignored.
- `req_addr` in W: byte address.
- `req_wdata` in W: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle strobe marking request completion.
- `rsp_rdata` out W: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned access or illegal `req_op`; qualified by `rsp_valid`.
- `mem_addr` out W: word-aligned address to the data memory (low 2 bits always 00).
- `mem_re` out 1: read enable. Memory read data is combinational.
- `mem_we` out 1: write enable. Memory commits on the next posedge.
- `mem_wdata` out W: full word to write.
- `mem_rdata` in W: memory read data.

## Operation
- Byte order is little-endian: lane k = bits [8k+7:8k], selected by `addr[1:0]`.
- Legal ops: 000, 001, 011, 100, 101. Any other value, including store with 100 or 101 treated as 000/001, follows these rules: bit 2 is masked for stores; other illegal values raise an error.
- Misaligned accesses: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 00.
- On accept, latch `req_we`, `req_op`, `req_addr` and `req_wdata`. Later changes on the `req_*` inputs are ignored.
- States:
  - IDLE: go to ERR if illegal or misaligned. Otherwise go to LOAD for a load, WRITE for `sw`, or RMW_RD for `sb`/`sh`.
  - LOAD: assert `mem_re`. Capture the extracted and extended lane data at the posedge, then go to DONE.
  - RMW_RD: assert `mem_re`. Capture `mem_rdata` into the merge register, then go to WRITE.
  - WRITE: assert `mem_we`. `mem_wdata` is `req_wdata` for `sw`, or the merge-register word with the target byte or half replaced. Go to DONE.
  - ERR: no memory strobes. Go to DONE with the error latched.
  - DONE: `rsp_valid` = 1, then go to IDLE.
- Extension rules:
  - Signed byte or half: replicate bit 7 or bit 15.
  - Unsigned byte or half: zero-fill.
  - Word: pass through.
- Only one of `mem_re` and `mem_we` is high in any cycle. `mem_addr` = {latched addr[W-1:2], 2'b00} in every non-IDLE state, and 0 in IDLE.

## Timing
- Cycle 0 is the accept posedge. `rsp_valid` is high in the cycle:
  - after 2 posedges for loads and `sw`;
  - after 3 posedges for `sb`/`sh`;
  - after 2 posedges for errors.
- `req_ready` returns to 1 in the cycle after DONE. There is no back-to-back accept during DONE.
- Memory writes commit at the posedge ending WRITE. This is before `rsp_valid` is high.
- Reset (`rst_n` = 0 at a posedge, from any state) applies the following:
  - state goes to IDLE;
  - `req_ready` = 1 after reset;
  - `rsp_valid`, `rsp_err`, `mem_re` and `mem_we` = 0;
  - `rsp_rdata`, `mem_addr`, `mem_wdata` and the merge register = 0.
- Reset while in WRITE: the write strobe still reaches memory at that edge, because memory samples `mem_we` at the same edge. The response is dropped.
- A request held with `req_valid` high during reset is accepted at the first posedge with `rst_n` = 1.

## Structure
- Add to `define.v`:
  - `` `LSU_OP_LB `` = 3'b000, `` `LSU_OP_LH `` = 3'b001, `` `LSU_OP_LW `` = 3'b011, `` `LSU_OP_LBU `` = 3'b100, `` `LSU_OP_LHU `` = 3'b101;
  - 3-bit state encodings `` `LSU_IDLE ``, `` `LSU_LOAD ``, `` `LSU_RMW_RD ``, `` `LSU_WRITE ``, `` `LSU_ERR ``, `` `LSU_DONE ``.
- One combinational sub-module, `lsu_lane`:
  - inputs: word, `addr[1:0]`, op, store data;
  - outputs: extended load value and merged store word.
  - It is shared by the LOAD and WRITE paths and unit-testable alone.

## Test plan
- Memory word at 0x40 = 0x8899AABB. `lb` at 0x41 → `rsp_rdata` = 0xFFFFFFAA, `rsp_err` = 0, `rsp_valid` 2 cycles after accept. `lbu` at 0x41 → 0x000000AA.
- `lh` at 0x42 → 0xFFFF8899. `lhu` at 0x42 → 0x00008899. `lw` at 0x40 → 0x8899AABB.
- `sb` of 0x12 at 0x43 over 0x8899AABB: one `mem_re` cycle, then one `mem_we` cycle with `mem_wdata` = 0x1299AABB. `rsp_valid` 3 cycles after accept. A following `lw` at 0x40 returns 0x1299AABB.
- `sh` of 0x5678 at 0x40 → word becomes 0x88995678. `sw` of 0xDEADBEEF at 0x44 → a single `mem_we` cycle with no `mem_re`.
- `lw` at 0x42, `lh` at 0x41, and `req_op` = 3'b010 each give `rsp_err` = 1, `rsp_rdata` = 0, and no `mem_re`/`mem_we` pulse. The memory word is unchanged.
- Drive `rst_n` low during RMW_RD of an `sb` → next cycle IDLE, `req_ready` = 1, no `mem_we`, no `rsp_valid`, memory unchanged.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared op codes, FSM state encoding and request-decode helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [2:0] LSU_OP_LB  = 3'b000;
  localparam logic [2:0] LSU_OP_LH  = 3'b001;
  localparam logic [2:0] LSU_OP_LW  = 3'b011;
  localparam logic [2:0] LSU_OP_LBU = 3'b100;
  localparam logic [2:0] LSU_OP_LHU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_LOAD   = 3'd1,
    LSU_RMW_RD = 3'd2,
    LSU_WRITE  = 3'd3,
    LSU_ERR    = 3'd4,
    LSU_DONE   = 3'd5
  } lsu_state_e;

  // Stores have no signedness, so the unsigned bit is dropped before decoding.
  function automatic logic [2:0] lsu_eff_op(input logic we, input logic [2:0] op);
    return we ? {1'b0, op[1:0]} : op;
  endfunction

  function automatic logic lsu_op_legal(input logic [2:0] op);
    case (op)
      LSU_OP_LB, LSU_OP_LH, LSU_OP_LW, LSU_OP_LBU, LSU_OP_LHU: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op[1:0])
      2'b01:   return addr_lo[0];
      2'b11:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus from the MEM stage and the word-only data memory bus.
interface lsu_req_if import load_store_unit_pkg::*; #(parameter int W = WORD_LEN);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_op;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if import load_store_unit_pkg::*; #(parameter int W = WORD_LEN);
  logic [W-1:0] mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata
  );
  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit_lane.sv
// Combinational byte-lane logic: extracts/extends load data and merges sub-word store data into a word.
module lsu_lane
  import load_store_unit_pkg::*;
#(
  parameter int W = WORD_LEN
) (
  input  logic [W-1:0] word_i,
  input  logic [1:0]   addr_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] sdata_i,
  output logic [W-1:0] load_o,
  output logic [W-1:0] store_o
);

  logic [7:0]  lane_b [4];
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       hit;
    logic [7:0] src;

    assign lane_b[gi] = word_i[8*gi +: 8];

    // A byte store always sources data byte 0; a half store sources byte 0 or 1 by lane parity.
    always_comb begin
      hit = 1'b1;
      src = sdata_i[8*gi +: 8];
      case (op_i[1:0])
        2'b00: begin
          hit = (addr_i == 2'(gi));
          src = sdata_i[7:0];
        end
        2'b01: begin
          hit = (addr_i[1] == 1'(gi / 2));
          src = sdata_i[8*(gi % 2) +: 8];
        end
        default: ;
      endcase
    end

    assign store_o[8*gi +: 8] = hit ? src : lane_b[gi];
  end

  assign sel_b = lane_b[addr_i];
  assign sel_h = addr_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_o = word_i;
    case (op_i)
      LSU_OP_LB:  load_o = {{(W-8){sel_b[7]}}, sel_b};
      LSU_OP_LBU: load_o = {{(W-8){1'b0}}, sel_b};
      LSU_OP_LH:  load_o = {{(W-16){sel_h[15]}}, sel_h};
      LSU_OP_LHU: load_o = {{(W-16){1'b0}}, sel_h};
      default:    load_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: one request at a time, sub-word stores done as read-modify-write on a word memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int W = WORD_LEN
) (
  input  logic   clk,
  input  logic   rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_e   state_q, state_d;
  logic         we_q, we_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] merge_q, merge_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;

  logic [2:0]   eff_op;
  logic [W-1:0] lane_word;
  logic [W-1:0] lane_load;
  logic [W-1:0] lane_store;

  assign eff_op = lsu_eff_op(req.req_we, req.req_op);

  // The lane sees live memory data while loading and the captured word while writing back.
  assign lane_word = (state_q == LSU_WRITE) ? merge_q : mem.mem_rdata;

  lsu_lane #(.W(W)) u_lane (
    .word_i  (lane_word),
    .addr_i  (addr_q[1:0]),
    .op_i    (op_q),
    .sdata_i (wdata_q),
    .load_o  (lane_load),
    .store_o (lane_store)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (req.req_valid) begin
          we_d    = req.req_we;
          op_d    = eff_op;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (!lsu_op_legal(eff_op) || lsu_misaligned(eff_op, req.req_addr[1:0]))
            state_d = LSU_ERR;
          else if (!req.req_we)
            state_d = LSU_LOAD;
          else if (eff_op[1:0] == 2'b11)
            state_d = LSU_WRITE;
          else
            state_d = LSU_RMW_RD;
        end
      end
      LSU_LOAD: begin
        rdata_d = lane_load;
        state_d = LSU_DONE;
      end
      LSU_RMW_RD: begin
        merge_d = mem.mem_rdata;
        state_d = LSU_WRITE;
      end
      LSU_WRITE: state_d = LSU_DONE;
      LSU_ERR: begin
        err_d   = 1'b1;
        state_d = LSU_DONE;
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req.req_ready = (state_q == LSU_IDLE);
  assign req.rsp_valid = (state_q == LSU_DONE);
  assign req.rsp_rdata = rdata_q;
  assign req.rsp_err   = err_q && (state_q == LSU_DONE);

  assign mem.mem_addr  = (state_q == LSU_IDLE) ? '0 : {addr_q[W-1:2], 2'b00};
  assign mem.mem_re    = (state_q == LSU_LOAD) || (state_q == LSU_RMW_RD);
  assign mem.mem_we    = (state_q == LSU_WRITE);
  assign mem.mem_wdata = (state_q == LSU_WRITE) ? lane_store : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner sequences, then random traffic vs a reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if #(.W(32)) req_bus ();
  lsu_mem_if #(.W(32)) mem_bus ();

  load_store_unit #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_bus.slave),
    .mem   (mem_bus.master)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h8899AABB : (32'h01010101 * 32'(i)) ^ 32'h5A3C0F00;
  endfunction

  // Word memory: combinational read, write committed on posedge.
  logic [31:0] mem [64];
  logic        mem_init_done = 1'b0;
  assign mem_bus.mem_rdata = mem[mem_bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_bus.mem_we) begin
      mem[mem_bus.mem_addr[7:2]] <= mem_bus.mem_wdata;
    end
  end

  logic [31:0] shadow [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the shadow memory.
  task automatic ref_model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int re, output int wr);
    int eop, size, sh;
    logic [31:0] word, mask, v;
    eop = we ? int'(op) % 4 : int'(op);
    case (eop % 4)
      0: size = 1;
      1: size = 2;
      3: size = 4;
      default: size = 0;
    endcase
    rdata = 0; err = 1'b0; lat = 2; re = 0; wr = 0;
    if (size == 0 || eop == 7 || (int'(addr[1:0]) % size) != 0) begin
      err = 1'b1;
      return;
    end
    word = shadow[addr[7:2]];
    sh   = 8 * int'(addr[1:0]);
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    if (!we) begin
      re = 1;
      v = (word >> sh) & mask;
      if (eop < 4 && size < 4 && v[8*size-1]) v = v | ~mask;
      rdata = v;
    end else begin
      wr = 1;
      if (size < 4) begin re = 1; lat = 3; end
      shadow[addr[7:2]] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_bus.req_valid = 1'b1;
    req_bus.req_we    = we;
    req_bus.req_op    = op;
    req_bus.req_addr  = addr;
    req_bus.req_wdata = wdata;
  endtask

  task automatic scramble_req();
    req_bus.req_valid = 1'b0;
    req_bus.req_we    = 1'($urandom);
    req_bus.req_op    = 3'($urandom);
    req_bus.req_addr  = $urandom;
    req_bus.req_wdata = $urandom;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int re, output int wr);
    int bad_addr;
    bit got;
    rdata = '0; err = 1'b0; lat = 99; re = 0; wr = 0; bad_addr = 0; got = 0;
    @(negedge clk);
    for (int n = 0; n < 20 && !req_bus.req_ready; n++) @(negedge clk);
    check("ready_wait", 32'(req_bus.req_ready), 32'd1);
    drive_req(we, op, addr, wdata);
    @(posedge clk);
    #1 scramble_req();
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_bus.mem_re) re++;
      if (mem_bus.mem_we) wr++;
      if ((mem_bus.mem_re || mem_bus.mem_we) &&
          (mem_bus.mem_addr !== {addr[31:2], 2'b00} || (mem_bus.mem_re && mem_bus.mem_we)))
        bad_addr++;
      if (req_bus.rsp_valid) begin
        got = 1; lat = c; rdata = req_bus.rsp_rdata; err = req_bus.rsp_err;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("mem_addr_bus", 32'(bad_addr), 32'd0);
    @(negedge clk);
    check("rsp_pulse", {30'd0, req_bus.rsp_valid, req_bus.req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] er, input logic ee,
                              input int el, input int ere, input int ewe);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_re = ere; v.exp_we = ewe;
    return v;
  endfunction

  logic [31:0] r_rdata, m_rdata;
  logic        r_err, m_err;
  int          r_lat, r_re, r_we, m_lat, m_re, m_we;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    req_bus.req_valid = 1'b0;
    req_bus.req_we    = 1'b0;
    req_bus.req_op    = 3'b000;
    req_bus.req_addr  = '0;
    req_bus.req_wdata = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(req_bus.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(req_bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", req_bus.rsp_rdata, 32'd0);
    check("rst_mem_strb",  {30'd0, mem_bus.mem_re, mem_bus.mem_we}, 32'd0);
    check("rst_mem_addr",  mem_bus.mem_addr, 32'd0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Directed table; entries run in order against the evolving memory.
    vecs.push_back(mk(0, 3'b000, 32'h41, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b100, 32'h41, 32'h0,        32'h000000AA, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b001, 32'h42, 32'h0,        32'hFFFF8899, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b101, 32'h42, 32'h0,        32'h00008899, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,        32'h8899AABB, 0, 2, 1, 0));
    vecs.push_back(mk(1, 3'b000, 32'h43, 32'h12,       32'h0,        0, 3, 1, 1));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,        32'h1299AABB, 0, 2, 1, 0));
    vecs.push_back(mk(1, 3'b001, 32'h40, 32'h5678,     32'h0,        0, 3, 1, 1));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,        32'h12995678, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b001, 32'h40, 32'h0,        32'h00005678, 0, 2, 1, 0));
    vecs.push_back(mk(1, 3'b011, 32'h44, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1));
    vecs.push_back(mk(0, 3'b011, 32'h44, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b011, 32'h42, 32'h11111111, 32'h0,        1, 2, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h41, 32'h11111111, 32'h0,        1, 2, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h40, 32'h11111111, 32'h0,        1, 2, 0, 0));
    vecs.push_back(mk(1, 3'b100, 32'h44, 32'hAB55,     32'h0,        0, 3, 1, 1));
    vecs.push_back(mk(1, 3'b110, 32'h40, 32'h22222222, 32'h0,        1, 2, 0, 0));
    vecs.push_back(mk(1, 3'b011, 32'h46, 32'h33333333, 32'h0,        1, 2, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h44, 32'h0,        32'h00000055, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b000, 32'h47, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,        32'h12995678, 0, 2, 1, 0));

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, r_rdata, r_err, r_lat, r_re, r_we);
      ref_model(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, m_rdata, m_err, m_lat, m_re, m_we);
      $display("vec %0d we=%0d op=%03b addr=0x%02h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d re=%0d we=%0d",
               i, vecs[i].we, vecs[i].op, vecs[i].addr[7:0], vecs[i].wdata, r_rdata, r_err, r_lat, r_re, r_we);
      check("vec_rdata", r_rdata, vecs[i].exp_rdata);
      check("vec_err",   32'(r_err), 32'(vecs[i].exp_err));
      check("vec_lat",   32'(r_lat), 32'(vecs[i].exp_lat));
      check("vec_re",    32'(r_re),  32'(vecs[i].exp_re));
      check("vec_we",    32'(r_we),  32'(vecs[i].exp_we));
      check("vec_mem",   mem[vecs[i].addr[7:2]], shadow[vecs[i].addr[7:2]]);
    end

    // Reset during the read phase of a byte store: no write, no response.
    @(negedge clk);
    drive_req(1'b1, 3'b000, 32'h41, 32'h77);
    @(posedge clk);
    #1 scramble_req();
    @(negedge clk);
    check("rmw_rd_re", 32'(mem_bus.mem_re), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rmw_rst_ready", 32'(req_bus.req_ready), 32'd1);
    check("rmw_rst_strb", {30'd0, mem_bus.mem_we, req_bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    r_we = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_bus.mem_we || req_bus.rsp_valid) r_we++;
    end
    check("rmw_rst_quiet", 32'(r_we), 32'd0);
    check("rmw_rst_mem", mem[16], shadow[16]);
    $display("seq reset-in-RMW_RD sb addr=0x41 -> mem[0x40]=0x%08h", mem[16]);

    // Reset during WRITE of a word store: the write still lands, response dropped.
    @(negedge clk);
    drive_req(1'b1, 3'b011, 32'h48, 32'hCAFEF00D);
    @(posedge clk);
    #1 scramble_req();
    @(negedge clk);
    check("wr_rst_we", 32'(mem_bus.mem_we), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("wr_rst_ready", 32'(req_bus.req_ready), 32'd1);
    rst_n = 1'b1;
    r_we = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_bus.mem_we || req_bus.rsp_valid) r_we++;
    end
    check("wr_rst_quiet", 32'(r_we), 32'd0);
    shadow[18] = 32'hCAFEF00D;
    check("wr_rst_mem", mem[18], shadow[18]);
    $display("seq reset-in-WRITE sw addr=0x48 -> mem[0x48]=0x%08h", mem[18]);

    // Request held through reset is taken at the first posedge with reset released.
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(1'b0, 3'b011, 32'h40, 32'h0);
    repeat (2) @(negedge clk);
    check("held_rst_idle", {30'd0, req_bus.req_ready, mem_bus.mem_re}, 32'd2);
    rst_n = 1'b1;
    @(posedge clk);
    #1 scramble_req();
    @(negedge clk);
    check("held_load_re", 32'(mem_bus.mem_re), 32'd1);
    @(negedge clk);
    check("held_rsp_valid", 32'(req_bus.rsp_valid), 32'd1);
    check("held_rsp_rdata", req_bus.rsp_rdata, shadow[16]);
    $display("seq held-through-reset lw addr=0x40 -> rdata=0x%08h", req_bus.rsp_rdata);

    // Random traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic        we;
      logic [2:0]  op;
      logic [31:0] addr, wdata;
      we    = 1'($urandom);
      op    = 3'($urandom_range(0, 7));
      addr  = 32'($urandom_range(0, 255));
      wdata = $urandom;
      run_txn(we, op, addr, wdata, r_rdata, r_err, r_lat, r_re, r_we);
      ref_model(we, op, addr, wdata, m_rdata, m_err, m_lat, m_re, m_we);
      $display("rnd %0d we=%0d op=%03b addr=0x%02h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
               t, we, op, addr[7:0], wdata, r_rdata, r_err, r_lat);
      check("rnd_rdata", r_rdata, m_rdata);
      check("rnd_err",   32'(r_err), 32'(m_err));
      check("rnd_lat",   32'(r_lat), 32'(m_lat));
      check("rnd_strb",  32'(r_re * 2 + r_we), 32'(m_re * 2 + m_we));
      check("rnd_mem",   mem[addr[7:2]], shadow[addr[7:2]]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
